// File: rtl/token_client.sv
// token_client
//
// Requester-side agent for a leaf of the tree arbiter. It converts a user's
// level request and done pulse into the four-phase token encoding a leaf
// arbiter cell expects: idle, request, lock, release. It also measures grant
// latency, optionally bounds how long the token is held, and flags
// arbiter-side protocol violations.
//
// Optional feature macro: TOKEN_CLIENT_TIMEOUT_EN
//   defined   : LOCK is forcibly released after MAX_HOLD lock cycles without
//               user_done, and revoked pulses for one cycle.
//   undefined : no hold counter; LOCK exits only on user_done; revoked = 0.
//
// Parameters
//   MAX_HOLD  maximum lock cycles before a forced release (>= 1)
//   WAIT_W    width of the saturating wait-latency counter
//
// Ports
//   clk        clock, all state updates on posedge
//   rst_n      synchronous active-low reset
//   user_req   level, user wants the token
//   user_done  pulse, user finished its critical section (used in LOCK only)
//   ack        grant from the leaf arbiter cell
//   req        phase to the arbiter: 0 idle, 1 request, 2 lock, 3 release
//   grant      high while req is lock
//   revoked    one-cycle pulse, aligned with the first release cycle, when a
//              hold timeout forced the release
//   wait_cnt   request cycles of the most recent request, saturating
//   err        sticky flag: ack seen outside the request phase

module token_client #(
    parameter int MAX_HOLD = 16,
    parameter int WAIT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              user_req,
    input  logic              user_done,
    input  logic              ack,
    output logic [1:0]        req,
    output logic              grant,
    output logic              revoked,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              err
);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("token_client: MAX_HOLD must be at least 1");
    end

    // Encoding matches the req phase values so the state drives req directly.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_LOCK    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

    state_t state;
    state_t state_next;
    logic   timeout;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A request is never withdrawn, and user_done is
    // only meaningful in LOCK. RELEASE always lasts exactly one cycle and
    // IDLE at least one, so a held user_req gives a 4-cycle rhythm.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (user_req) state_next = ST_REQUEST;
            ST_REQUEST: if (ack) state_next = ST_LOCK;
            ST_LOCK:    if (user_done || timeout) state_next = ST_RELEASE;
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the registered state only.
    // ------------------------------------------------------------------
    always_comb begin
        req   = state;
        grant = (state == ST_LOCK);
    end

    // ------------------------------------------------------------------
    // Hold timeout
    // ------------------------------------------------------------------
`ifdef TOKEN_CLIENT_TIMEOUT_EN
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    // Counts lock cycles including the current one: 1 on the first LOCK
    // cycle, so reaching HOLD_MAX means MAX_HOLD lock cycles have been shown.
    logic [HOLD_W-1:0] hold_cnt;

    // A simultaneous user_done wins, so such a release is not a revocation.
    assign timeout = (state == ST_LOCK) && (hold_cnt == HOLD_MAX) && !user_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state_next != ST_LOCK) begin
            hold_cnt <= '0;
        end else if (state != ST_LOCK) begin
            hold_cnt <= HOLD_W'(1);
        end else begin
            // Staying in LOCK implies hold_cnt < HOLD_MAX, so no wrap.
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            revoked <= 1'b0;
        end else begin
            revoked <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign revoked = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Wait latency: cleared as a request starts, counts every edge spent
    // in REQUEST (including the one that takes ack), then holds.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE && user_req) begin
            wait_cnt <= '0;
        end else if (state == ST_REQUEST && wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Protocol error: ack is only legal while requesting. Sticky until
    // reset; it never alters the phase sequence.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (ack && state != ST_REQUEST) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_token_client.sv
module tb_token_client;

    localparam int MH0 = 16;
    localparam int WW0 = 8;
    localparam int MH1 = 3;
    localparam int WW1 = 4;

`ifdef TOKEN_CLIENT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_LOCK = 2;
    localparam int P_REL  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, user_req, user_done, ack;
    logic [1:0]     req0, req1;
    logic           grant0, grant1, rev0, rev1, err0, err1;
    logic [WW0-1:0] wait0;
    logic [WW1-1:0] wait1;

    token_client #(.MAX_HOLD(MH0), .WAIT_W(WW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .user_req(user_req), .user_done(user_done),
        .ack(ack), .req(req0), .grant(grant0), .revoked(rev0),
        .wait_cnt(wait0), .err(err0)
    );

    token_client #(.MAX_HOLD(MH1), .WAIT_W(WW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .user_req(user_req), .user_done(user_done),
        .ack(ack), .req(req1), .grant(grant1), .revoked(rev1),
        .wait_cnt(wait1), .err(err1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: phase, lock age (lock cycles shown so far), unbounded
    // request-cycle count clipped only when compared, sticky error.
    int m_phase [2];
    int m_age   [2];
    int m_wait  [2];
    bit m_err   [2];
    bit m_rev   [2];
    int m_hold  [2] = '{MH0, MH1};
    int m_wmax  [2] = '{(1 << WW0) - 1, (1 << WW1) - 1};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_phase[k] = P_IDLE;
                m_age[k]   = 0;
                m_wait[k]  = 0;
                m_err[k]   = 1'b0;
                m_rev[k]   = 1'b0;
            end else begin
                int nxt;
                nxt      = m_phase[k];
                m_rev[k] = 1'b0;
                if (ack && m_phase[k] != P_REQ) m_err[k] = 1'b1;
                case (m_phase[k])
                    P_IDLE: if (user_req) begin nxt = P_REQ; m_wait[k] = 0; end
                    P_REQ: begin
                        m_wait[k]++;
                        if (ack) begin nxt = P_LOCK; m_age[k] = 1; end
                    end
                    P_LOCK: begin
                        if (user_done) nxt = P_REL;
                        else if (TO_EN && m_age[k] >= m_hold[k]) begin
                            nxt = P_REL;
                            m_rev[k] = 1'b1;
                        end else m_age[k]++;
                    end
                    default: nxt = P_IDLE;
                endcase
                m_phase[k] = nxt;
            end
        end
    endtask

    function automatic int exp_wait(input int k);
        return (m_wait[k] > m_wmax[k]) ? m_wmax[k] : m_wait[k];
    endfunction

    task automatic compare_all();
        check("d0_req",     req0,   m_phase[0]);
        check("d0_grant",   grant0, m_phase[0] == P_LOCK);
        check("d0_revoked", rev0,   m_rev[0]);
        check("d0_wait",    wait0,  exp_wait(0));
        check("d0_err",     err0,   m_err[0]);
        check("d1_req",     req1,   m_phase[1]);
        check("d1_grant",   grant1, m_phase[1] == P_LOCK);
        check("d1_revoked", rev1,   m_rev[1]);
        check("d1_wait",    wait1,  exp_wait(1));
        check("d1_err",     err1,   m_err[1]);
    endtask

    // Drive inputs, take one edge, advance the model, compare 1ns later.
    task automatic step(input bit r, input bit ur, input bit ud, input bit a);
        rst_n     = r;
        user_req  = ur;
        user_done = ud;
        ack       = a;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        bit       rst_n;
        bit       ureq;
        bit       done;
        bit       ack;
        int       exp_req;
        int       exp_wait;
        bit       exp_err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int lock_cycles;
        int rev_seen;

        // Hand-derived sequence: basic transaction, ignored withdrawal,
        // ack in IDLE and LOCK setting err, err cleared only by reset.
        tbl[0]  = '{0, 0, 0, 0, P_IDLE, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, P_REQ,  0, 0};
        tbl[2]  = '{1, 0, 0, 0, P_REQ,  1, 0};
        tbl[3]  = '{1, 0, 0, 0, P_REQ,  2, 0};
        tbl[4]  = '{1, 0, 0, 1, P_LOCK, 3, 0};
        tbl[5]  = '{1, 0, 0, 0, P_LOCK, 3, 0};
        tbl[6]  = '{1, 0, 1, 0, P_REL,  3, 0};
        tbl[7]  = '{1, 0, 0, 0, P_IDLE, 3, 0};
        tbl[8]  = '{1, 0, 0, 1, P_IDLE, 3, 1};
        tbl[9]  = '{1, 1, 0, 0, P_REQ,  0, 1};
        tbl[10] = '{1, 0, 0, 1, P_LOCK, 1, 1};
        tbl[11] = '{1, 0, 0, 1, P_LOCK, 1, 1};
        tbl[12] = '{1, 0, 1, 0, P_REL,  1, 1};
        tbl[13] = '{1, 0, 0, 0, P_IDLE, 1, 1};
        tbl[14] = '{0, 0, 0, 0, P_IDLE, 0, 0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst_n, tbl[i].ureq, tbl[i].done, tbl[i].ack);
            check($sformatf("tbl%0d_req", i),  req0,  tbl[i].exp_req);
            check($sformatf("tbl%0d_wait", i), wait0, tbl[i].exp_wait);
            check($sformatf("tbl%0d_err", i),  err0,  tbl[i].exp_err);
        end

        // Held user_req with immediate ack: lock, release, idle, request...
        step(1, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            int pat;
            step(1, 1, m_phase[0] == P_LOCK, m_phase[0] == P_REQ);
            case (i % 4)
                0: pat = P_LOCK;
                1: pat = P_REL;
                2: pat = P_IDLE;
                default: pat = P_REQ;
            endcase
            check($sformatf("b2b%0d_req", i), req0, pat);
            if (i % 4 == 0) check($sformatf("b2b%0d_wait", i), wait0, 1);
        end

        // Long hold with no user_done (ends above in REQUEST).
        step(1, 0, 0, 1);
        lock_cycles = 1;
        rev_seen    = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            if (req0 == 2'(P_LOCK)) lock_cycles++;
            if (rev0) rev_seen++;
        end
        check("hold_lock_cycles", lock_cycles, TO_EN ? MH0 : 21);
        check("hold_revoked",     rev_seen,    TO_EN ? 1 : 0);
        check("hold_final_req",   req0,        TO_EN ? P_IDLE : P_LOCK);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);

        // Wait counter saturation in the narrow instance.
        step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
        check("sat_wait_w4", wait1, 15);
        check("sat_wait_w8", wait0, 20);
        step(1, 0, 0, 1);

        // Reset during LOCK: straight to idle, then a stray done is ignored.
        step(1, 0, 0, 0);
        check("pre_rst_lock", req0, P_LOCK);
        step(0, 0, 0, 0);
        check("rst_lock_req",   req0,   P_IDLE);
        check("rst_lock_grant", grant0, 0);
        step(1, 0, 1, 0);
        check("post_rst_done_req", req0, P_IDLE);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit r, ur, ud, a;
            r  = ($urandom_range(0, 99) != 0);
            ur = ($urandom_range(0, 9) < 7);
            ud = ($urandom_range(0, 9) < 3);
            if (m_phase[0] == P_REQ || m_phase[1] == P_REQ)
                a = ($urandom_range(0, 9) < 4);
            else
                a = ($urandom_range(0, 99) < 3);
            step(r, ur, ud, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
